alu_logic_sequencer: RTL and testbench

- Clocked command front-end for the combinational 8-bit logic unit (select 00 = AND, 01 = OR, result on H).
- Accepts one operation at a time over a valid/ready command channel and drives the unit's A, B, S1 and S0 inputs from registers.
- Waits a programmable settle time, then captures H with zero and error flags and presents it on a valid/ready result channel.
- Sits between the ALU control path and the logic unit, so the unit is never driven with unsupported select codes (10, 11).

---
 rtl/alu_logic_sequencer_pkg.sv | 27 ++
 rtl/alu_logic_sequencer_if.sv | 47 ++++
 rtl/alu_logic_sequencer.sv | 127 ++++++++++++
 tb/tb_alu_logic_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_logic_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_logic_sequencer_pkg
//  Purpose  : Shared definitions for the logic-unit command sequencer:
//             operation codes, FSM state encoding and the default data width.
//  Revision : 1.0 - initial release
// ============================================================================
package alu_logic_sequencer_pkg;

   localparam int DEFAULT_W = 8;

   localparam logic [1:0] OP_AND = 2'b00;
   localparam logic [1:0] OP_OR  = 2'b01;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_RESULT = 2'd2
   } state_t;

   // Only AND and OR exist in the logic unit; 10/11 must never reach it.
   function automatic logic op_supported(input logic [1:0] op);
      return (op == OP_AND) || (op == OP_OR);
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_logic_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_logic_sequencer_if
//  Purpose  : Bundles the command channel, the logic-unit drive/return bus
//             and the result channel of the sequencer.
//  Ports    : cmd_valid/cmd_ready/cmd_op/cmd_a/cmd_b  - command channel
//             alu_a/alu_b/alu_s1/alu_s0/alu_h         - logic-unit bus
//             res_valid/res_ready/res_data/res_zero/res_err - result channel
//  Modports : slave  - the sequencer itself
//             master - the control path / logic unit around it
//  Revision : 1.0 - initial release
// ============================================================================
interface alu_logic_sequencer_if
   import alu_logic_sequencer_pkg::*;
#(
   parameter int W = DEFAULT_W
);
   logic         cmd_valid;
   logic         cmd_ready;
   logic [1:0]   cmd_op;
   logic [W-1:0] cmd_a;
   logic [W-1:0] cmd_b;
   logic [W-1:0] alu_a;
   logic [W-1:0] alu_b;
   logic         alu_s1;
   logic         alu_s0;
   logic [W-1:0] alu_h;
   logic         res_valid;
   logic         res_ready;
   logic [W-1:0] res_data;
   logic         res_zero;
   logic         res_err;

   modport slave (
      input  cmd_valid, cmd_op, cmd_a, cmd_b, alu_h, res_ready,
      output cmd_ready, alu_a, alu_b, alu_s1, alu_s0,
             res_valid, res_data, res_zero, res_err
   );

   modport master (
      output cmd_valid, cmd_op, cmd_a, cmd_b, alu_h, res_ready,
      input  cmd_ready, alu_a, alu_b, alu_s1, alu_s0,
             res_valid, res_data, res_zero, res_err
   );

endinterface
`default_nettype wire

// File: rtl/alu_logic_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : alu_logic_sequencer
//  Purpose  : Clocked command front-end for the 8-bit AND/OR logic unit.
//             Accepts one command, drives the unit from registers, waits
//             SETTLE_CYCLES edges, captures H with zero/error flags and holds
//             it on a valid/ready result channel. Unsupported op codes are
//             answered with an error result without touching the unit.
//  Ports    : clk  - rising-edge clock
//             rst  - asynchronous active-high reset
//             bus  - alu_logic_sequencer_if.slave (command, unit, result)
//  Revision : 1.0 - initial release
// ============================================================================
module alu_logic_sequencer
   import alu_logic_sequencer_pkg::*;
#(
   parameter int W             = DEFAULT_W,
   parameter int SETTLE_CYCLES = 1,   // legal 1..15
   parameter int CNT_W         = 4    // 2**CNT_W > SETTLE_CYCLES
)(
   input  wire logic              clk,
   input  wire logic              rst,
   alu_logic_sequencer_if.slave   bus
);

   localparam logic [CNT_W-1:0] c_settle_init = CNT_W'(SETTLE_CYCLES - 1);

   state_t           state_q,     state_d;
   logic [CNT_W-1:0] cnt_q,       cnt_d;
   logic [W-1:0]     alu_a_q,     alu_a_d;
   logic [W-1:0]     alu_b_q,     alu_b_d;
   logic [1:0]       alu_op_q,    alu_op_d;
   logic             res_valid_q, res_valid_d;
   logic [W-1:0]     res_data_q,  res_data_d;
   logic             res_zero_q,  res_zero_d;
   logic             res_err_q,   res_err_d;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_op_d    = alu_op_q;
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      res_zero_d  = res_zero_q;
      res_err_d   = res_err_q;

      case (state_q)
         ST_IDLE: begin
            // cmd_ready is high throughout IDLE, so cmd_valid alone accepts.
            if (bus.cmd_valid) begin
               if (op_supported(bus.cmd_op)) begin
                  alu_a_d  = bus.cmd_a;
                  alu_b_d  = bus.cmd_b;
                  alu_op_d = bus.cmd_op;
                  cnt_d    = c_settle_init;
                  state_d  = ST_SETTLE;
               end else begin
                  // Error answered directly; the unit keeps its old inputs.
                  res_data_d  = '0;
                  res_zero_d  = 1'b0;
                  res_err_d   = 1'b1;
                  res_valid_d = 1'b1;
                  state_d     = ST_RESULT;
               end
            end
         end
         ST_SETTLE: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               res_data_d  = bus.alu_h;
               res_zero_d  = (bus.alu_h == '0);
               res_err_d   = 1'b0;
               res_valid_d = 1'b1;
               state_d     = ST_RESULT;
            end
         end
         ST_RESULT: begin
            // Data and flags are left in place after the handshake.
            if (bus.res_ready) begin
               res_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_op_q    <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_zero_q  <= 1'b0;
         res_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_op_q    <= alu_op_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         res_zero_q  <= res_zero_d;
         res_err_q   <= res_err_d;
      end
   end

   // State is already IDLE during reset, so ready must be gated by rst too.
   assign bus.cmd_ready = (state_q == ST_IDLE) && !rst;
   assign bus.alu_a     = alu_a_q;
   assign bus.alu_b     = alu_b_q;
   assign bus.alu_s1    = alu_op_q[1];
   assign bus.alu_s0    = alu_op_q[0];
   assign bus.res_valid = res_valid_q;
   assign bus.res_data  = res_data_q;
   assign bus.res_zero  = res_zero_q;
   assign bus.res_err   = res_err_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_logic_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_logic_sequencer
//  Purpose  : Self-checking bench for alu_logic_sequencer. Two instances are
//             used: settle time 1 (index 0) and settle time 3 (index 1), each
//             with a behavioural AND/OR logic unit attached.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_logic_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   alu_logic_sequencer_if #(.W(8)) b1 ();
   alu_logic_sequencer_if #(.W(8)) b3 ();

   alu_logic_sequencer #(.W(8), .SETTLE_CYCLES(1), .CNT_W(4)) dut1 (
      .clk (clk), .rst (rst), .bus (b1.slave)
   );
   alu_logic_sequencer #(.W(8), .SETTLE_CYCLES(3), .CNT_W(4)) dut3 (
      .clk (clk), .rst (rst), .bus (b3.slave)
   );

   // The attached combinational logic unit.
   assign b1.alu_h = ({b1.alu_s1, b1.alu_s0} == 2'b00) ? (b1.alu_a & b1.alu_b) :
                     ({b1.alu_s1, b1.alu_s0} == 2'b01) ? (b1.alu_a | b1.alu_b) : 8'h00;
   assign b3.alu_h = ({b3.alu_s1, b3.alu_s0} == 2'b00) ? (b3.alu_a & b3.alu_b) :
                     ({b3.alu_s1, b3.alu_s0} == 2'b01) ? (b3.alu_a | b3.alu_b) : 8'h00;

   typedef struct packed {
      logic       cmd_ready;
      logic [7:0] alu_a;
      logic [7:0] alu_b;
      logic [1:0] alu_s;
      logic       res_valid;
      logic [7:0] res_data;
      logic       res_zero;
      logic       res_err;
   } obs_t;

   typedef struct {
      logic [1:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] data;
      logic       zero;
      logic       err;
   } vec_t;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model of the unit-facing registers and settle times.
   logic [7:0] m_alu_a  [2];
   logic [7:0] m_alu_b  [2];
   logic [1:0] m_alu_op [2];
   int         settle   [2] = '{1, 3};

   vec_t vecs [8];

   function automatic obs_t get_obs(input int w);
      obs_t o;
      if (w == 0) begin
         o.cmd_ready = b1.cmd_ready; o.alu_a = b1.alu_a; o.alu_b = b1.alu_b;
         o.alu_s = {b1.alu_s1, b1.alu_s0}; o.res_valid = b1.res_valid;
         o.res_data = b1.res_data; o.res_zero = b1.res_zero; o.res_err = b1.res_err;
      end else begin
         o.cmd_ready = b3.cmd_ready; o.alu_a = b3.alu_a; o.alu_b = b3.alu_b;
         o.alu_s = {b3.alu_s1, b3.alu_s0}; o.res_valid = b3.res_valid;
         o.res_data = b3.res_data; o.res_zero = b3.res_zero; o.res_err = b3.res_err;
      end
      return o;
   endfunction

   task automatic set_cmd(input int w, input logic v, input logic [1:0] op,
                          input logic [7:0] a, input logic [7:0] b);
      if (w == 0) begin
         b1.cmd_valid = v; b1.cmd_op = op; b1.cmd_a = a; b1.cmd_b = b;
      end else begin
         b3.cmd_valid = v; b3.cmd_op = op; b3.cmd_a = a; b3.cmd_b = b;
      end
   endtask

   task automatic set_rdy(input int w, input logic r);
      if (w == 0) b1.res_ready = r;
      else        b3.res_ready = r;
   endtask

   task automatic check(input string name, input int w,
                        input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s (dut%0d): actual=0x%0h expected=0x%0h", name, w, act, exp);
      end
   endtask

   // Expected result of one command, from the operation definition.
   task automatic ref_result(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                             output logic [7:0] d, output logic z, output logic e);
      e = (op == 2'b10) || (op == 2'b11);
      d = (op == 2'b00) ? (a & b) : (op == 2'b01) ? (a | b) : 8'h00;
      z = !e && (d == 8'h00);
   endtask

   // One full command: accept, wait for result, optional backpressure, drain.
   task automatic do_cmd(input int w, input logic [1:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] e_data,
                         input logic e_zero, input logic e_err, input int hold);
      obs_t o;
      int   t;
      int   lat;
      int   e_lat;
      e_lat = e_err ? 0 : settle[w];
      o = get_obs(w);
      t = 0;
      while (!o.cmd_ready && t < 20) begin
         @(negedge clk); t++; o = get_obs(w);
      end
      check("cmd_ready_before_accept", w, 32'(o.cmd_ready), 32'd1);
      set_cmd(w, 1'b1, op, a, b);
      @(posedge clk);
      @(negedge clk);
      set_cmd(w, 1'b0, 2'($urandom), 8'($urandom), 8'($urandom));
      if (!e_err) begin
         m_alu_a[w] = a; m_alu_b[w] = b; m_alu_op[w] = op;
      end
      o = get_obs(w);
      check("alu_a_after_accept", w, 32'(o.alu_a), 32'(m_alu_a[w]));
      check("alu_b_after_accept", w, 32'(o.alu_b), 32'(m_alu_b[w]));
      check("alu_sel_after_accept", w, 32'(o.alu_s), 32'(m_alu_op[w]));
      lat = 0;
      while (!o.res_valid && lat < 40) begin
         @(negedge clk); lat++; o = get_obs(w);
         if (!o.res_valid) check("cmd_ready_low_settle", w, 32'(o.cmd_ready), 32'd0);
      end
      check("result_latency", w, 32'(lat), 32'(e_lat));
      check("res_data", w, 32'(o.res_data), 32'(e_data));
      check("res_zero", w, 32'(o.res_zero), 32'(e_zero));
      check("res_err", w, 32'(o.res_err), 32'(e_err));
      check("cmd_ready_low_result", w, 32'(o.cmd_ready), 32'd0);
      repeat (hold) begin
         set_cmd(w, 1'b0, 2'($urandom), 8'($urandom), 8'($urandom));
         @(negedge clk);
         o = get_obs(w);
         check("hold_res_valid", w, 32'(o.res_valid), 32'd1);
         check("hold_res_fields", w, {21'd0, o.res_data, o.res_zero, o.res_err},
               {21'd0, e_data, e_zero, e_err});
         check("hold_cmd_ready", w, 32'(o.cmd_ready), 32'd0);
      end
      set_rdy(w, 1'b1);
      @(negedge clk);
      set_rdy(w, 1'b0);
      o = get_obs(w);
      check("drain_res_valid", w, 32'(o.res_valid), 32'd0);
      check("drain_cmd_ready", w, 32'(o.cmd_ready), 32'd1);
      check("drain_res_kept", w, {21'd0, o.res_data, o.res_zero, o.res_err},
            {21'd0, e_data, e_zero, e_err});
      check("drain_alu_kept", w, {14'd0, o.alu_a, o.alu_b, o.alu_s},
            {14'd0, m_alu_a[w], m_alu_b[w], m_alu_op[w]});
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin : stim
      obs_t       o;
      logic [1:0] op;
      logic [7:0] a, b, d;
      logic       z, e;
      int         w;

      vecs[0] = '{2'b00, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0};
      vecs[1] = '{2'b01, 8'hA5, 8'h5A, 8'hFF, 1'b0, 1'b0};
      vecs[2] = '{2'b00, 8'h0F, 8'hF0, 8'h00, 1'b1, 1'b0};
      vecs[3] = '{2'b01, 8'h11, 8'h22, 8'h33, 1'b0, 1'b0};
      vecs[4] = '{2'b10, 8'h77, 8'h88, 8'h00, 1'b0, 1'b1};
      vecs[5] = '{2'b11, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1};
      vecs[6] = '{2'b01, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};
      vecs[7] = '{2'b00, 8'hFF, 8'h81, 8'h81, 1'b0, 1'b0};

      for (int i = 0; i < 2; i++) begin
         m_alu_a[i] = 8'h00; m_alu_b[i] = 8'h00; m_alu_op[i] = 2'b00;
         set_cmd(i, 1'b0, 2'b00, 8'h00, 8'h00);
         set_rdy(i, 1'b0);
      end

      // Reset state, including cmd_ready held low while rst is high.
      #2;
      for (int i = 0; i < 2; i++) begin
         o = get_obs(i);
         check("reset_outputs", i, 32'(o), 32'd0);
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check("ready_after_reset", 0, 32'(get_obs(0).cmd_ready), 32'd1);

      // Directed table on the settle-1 instance; entry 3 sets alu_a = 0x11
      // so the following error entry shows the unit inputs are left alone.
      for (int i = 0; i < 8; i++) begin
         do_cmd(0, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].data,
                vecs[i].zero, vecs[i].err, (i == 1) ? 5 : (i % 3));
      end

      // Settle-3 instance: latency of exactly three edges.
      do_cmd(1, 2'b01, 8'hA5, 8'h5A, 8'hFF, 1'b0, 1'b0, 2);
      do_cmd(1, 2'b11, 8'h12, 8'h34, 8'h00, 1'b0, 1'b1, 1);

      // Asynchronous reset in the middle of SETTLE.
      o = get_obs(1);
      check("ready_before_rst_cmd", 1, 32'(o.cmd_ready), 32'd1);
      set_cmd(1, 1'b1, 2'b00, 8'hFF, 8'h0F);
      @(posedge clk);
      @(negedge clk);
      set_cmd(1, 1'b0, 2'b00, 8'h00, 8'h00);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      o = get_obs(1);
      check("async_reset_outputs", 1, 32'(o), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         m_alu_a[i] = 8'h00; m_alu_b[i] = 8'h00; m_alu_op[i] = 2'b00;
      end
      repeat (6) begin
         @(negedge clk);
         o = get_obs(1);
         check("no_stale_result", 1, 32'(o.res_valid), 32'd0);
         check("ready_after_rst", 1, 32'(o.cmd_ready), 32'd1);
      end

      // Random commands against the reference model.
      for (int i = 0; i < 60; i++) begin
         w  = int'($urandom_range(0, 1));
         op = 2'($urandom);
         a  = 8'($urandom);
         b  = ($urandom_range(0, 3) == 0) ? ~a : 8'($urandom);
         ref_result(op, a, b, d, z, e);
         do_cmd(w, op, a, b, d, z, e, int'($urandom_range(0, 3)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
